// File: rtl/router_pkt_tx_if.sv
// Host and router signal bundle for the packet transmitter.
// The master view drives the host requests and the router status inputs.
// The slave view is the transmitter itself.
interface router_pkt_tx_if;
  logic       start;
  logic [1:0] dest;
  logic [5:0] len;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       busy;
  logic       err;
  logic       packet_valid;
  logic [7:0] dout;
  logic       ready;
  logic       done;
  logic       pkt_err;
  logic       reject;
  logic       timeout;

  modport master (
    output start, dest, len, pl_data, pl_valid, busy, err,
    input  pl_ready, packet_valid, dout, ready, done, pkt_err, reject, timeout
  );

  modport slave (
    input  start, dest, len, pl_data, pl_valid, busy, err,
    output pl_ready, packet_valid, dout, ready, done, pkt_err, reject, timeout
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet transmitter for the 1x3 router input side.
// The block buffers a whole payload from the host, then sends the header,
// the payload and the parity byte, stalling on busy. After the packet it
// samples the router err flag and reports the result with done/pkt_err.
module router_pkt_tx #(
  parameter int unsigned CHK_CYCLES = 3,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            resetn,
  router_pkt_tx_if.slave  bus
);

  localparam logic [3:0]  CHK_INIT  = 4'(CHK_CYCLES);
  localparam logic [15:0] BUSY_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_CHECK
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  dest_q, dest_d;
  logic [5:0]  len_q, len_d;
  logic [7:0]  parity_q, parity_d;
  logic [5:0]  wr_idx_q, wr_idx_d;
  logic [5:0]  rd_idx_q, rd_idx_d;
  logic [15:0] busy_cnt_q, busy_cnt_d;
  logic [3:0]  chk_cnt_q, chk_cnt_d;
  logic [7:0]  dout_q, dout_d;
  logic        pv_q, pv_d;
  logic        done_q, done_d;
  logic        pkt_err_q, pkt_err_d;
  logic        reject_q, reject_d;
  logic        timeout_q, timeout_d;
  logic        buf_we;
  logic [7:0]  pl_buf_q [64];

  // Next-state and output decode for the transmit sequencer.
  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    len_d      = len_q;
    parity_d   = parity_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    busy_cnt_d = '0;
    chk_cnt_d  = chk_cnt_q;
    dout_d     = dout_q;
    pv_d       = pv_q;
    done_d     = 1'b0;
    pkt_err_d  = pkt_err_q;
    reject_d   = 1'b0;
    timeout_d  = 1'b0;
    buf_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.dest == 2'd3 || bus.len == 6'd0) begin
            reject_d = 1'b1;
          end else begin
            dest_d   = bus.dest;
            len_d    = bus.len;
            parity_d = {bus.len, bus.dest};
            wr_idx_d = '0;
            rd_idx_d = '0;
            state_d  = S_FILL;
          end
        end
      end

      S_FILL: begin
        if (bus.pl_valid) begin
          buf_we   = 1'b1;
          parity_d = parity_q ^ bus.pl_data;
          wr_idx_d = wr_idx_q + 6'd1;
          if (wr_idx_q == len_q - 6'd1) begin
            dout_d  = {len_q, dest_q};
            pv_d    = 1'b1;
            state_d = S_HEADER;
          end
        end
      end

      S_HEADER, S_PAYLOAD, S_PARITY: begin
        if (bus.busy) begin
          // A stuck router aborts the packet once the stall budget is spent.
          if (busy_cnt_q == BUSY_LAST) begin
            pv_d      = 1'b0;
            dout_d    = '0;
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            busy_cnt_d = busy_cnt_q + 16'd1;
          end
        end else begin
          case (state_q)
            S_HEADER: begin
              dout_d   = pl_buf_q[6'd0];
              rd_idx_d = 6'd1;
              state_d  = S_PAYLOAD;
            end
            S_PAYLOAD: begin
              if (rd_idx_q == len_q) begin
                dout_d  = parity_q;
                pv_d    = 1'b0;
                state_d = S_PARITY;
              end else begin
                dout_d   = pl_buf_q[rd_idx_q];
                rd_idx_d = rd_idx_q + 6'd1;
              end
            end
            default: begin
              dout_d    = '0;
              chk_cnt_d = CHK_INIT;
              state_d   = S_CHECK;
            end
          endcase
        end
      end

      S_CHECK: begin
        chk_cnt_d = chk_cnt_q - 4'd1;
        if (chk_cnt_q == 4'd1) begin
          pkt_err_d = bus.err;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      busy_cnt_q <= '0;
      chk_cnt_q  <= '0;
      dout_q     <= '0;
      pv_q       <= 1'b0;
      done_q     <= 1'b0;
      pkt_err_q  <= 1'b0;
      reject_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      busy_cnt_q <= busy_cnt_d;
      chk_cnt_q  <= chk_cnt_d;
      dout_q     <= dout_d;
      pv_q       <= pv_d;
      done_q     <= done_d;
      pkt_err_q  <= pkt_err_d;
      reject_q   <= reject_d;
      timeout_q  <= timeout_d;
    end
  end

  // Packet fields are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    dest_q   <= dest_d;
    len_q    <= len_d;
    parity_q <= parity_d;
  end

  // Payload buffer write port, active only while filling.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      pl_buf_q[wr_idx_q] <= bus.pl_data;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.packet_valid = pv_q;
  assign bus.done         = done_q;
  assign bus.pkt_err      = pkt_err_q;
  assign bus.reject       = reject_q;
  assign bus.timeout      = timeout_q;
  assign bus.ready        = (state_q == S_IDLE);
  assign bus.pl_ready     = (state_q == S_FILL);

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: directed packets from the test plan
// plus randomized packets, all checked against a byte-list packet model.
module tb_router_pkt_tx;

  localparam int CHK = 3;
  localparam int TO  = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  router_pkt_tx_if bus ();

  router_pkt_tx #(
    .CHK_CYCLES(CHK),
    .TIMEOUT   (TO)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0] pay [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue a start and stream the payload; returns with the header on dout.
  task automatic start_and_fill(input logic [1:0] d, input logic [5:0] l, input int pv_mode);
    int i;
    int cyc;
    logic v;
    chk("ready_idle", bus.ready, 1);
    bus.start = 1'b1;
    bus.dest  = d;
    bus.len   = l;
    @(negedge clk);
    bus.start = 1'b0;
    chk("fill_entry", bus.pl_ready, 1);
    i = 0;
    cyc = 0;
    while (i < int'(l) && cyc < 1000) begin
      case (pv_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.pl_valid = v;
      bus.pl_data  = pay[i];
      @(negedge clk);
      if (v) i++;
      cyc++;
    end
    bus.pl_valid = 1'b0;
    chk("fill_complete", i, int'(l));
    if (pv_mode == 1) chk("fill_cycles", cyc, 2 * int'(l) - 1);
    chk("pl_ready_drop", bus.pl_ready, 0);
  endtask

  // Full packet: model builds the expected byte list, bench checks every cycle.
  task automatic run_packet(input logic [1:0] d, input logic [5:0] l, input int pv_mode,
                            input int busy_mode, input logic e);
    logic [7:0] exp_q [$];
    logic [7:0] par;
    int k;
    int cyc;
    int run;
    int held;
    int n;
    logic b;
    exp_q.delete();
    par = {l, d};
    exp_q.push_back(par);
    for (int j = 0; j < int'(l); j++) begin
      exp_q.push_back(pay[j]);
      par = par ^ pay[j];
    end
    exp_q.push_back(par);

    start_and_fill(d, l, pv_mode);

    k = 0;
    cyc = 0;
    run = 0;
    held = 0;
    while (k < int'(l) + 2 && cyc < 2000) begin
      chk("tx_byte", bus.dout, exp_q[k]);
      chk("tx_pv", bus.packet_valid, (k <= int'(l)) ? 1 : 0);
      chk("tx_no_done", bus.done, 0);
      if (k == 1) held++;
      case (busy_mode)
        0:       b = 1'b0;
        1:       b = (k == 1 && held <= 2);
        default: b = (run < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      endcase
      run = b ? run + 1 : 0;
      bus.busy  = b;
      bus.start = 1'($urandom_range(0, 1));
      bus.dest  = 2'($urandom);
      bus.len   = 6'($urandom);
      @(negedge clk);
      cyc++;
      if (!b) k++;
    end
    bus.busy  = 1'b0;
    bus.start = 1'b0;
    bus.err   = e;
    chk("tx_finished", k, int'(l) + 2);
    if (busy_mode == 1) chk("stall_hold", held, 3);
    chk("dout_after_parity", bus.dout, 0);
    chk("pv_after_parity", bus.packet_valid, 0);

    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_latency", n, CHK);
    chk("pkt_err", bus.pkt_err, e);
    chk("ready_with_done", bus.ready, 1);
    @(negedge clk);
    bus.err = 1'b0;
    chk("done_pulse", bus.done, 0);
    chk("pkt_err_held", bus.pkt_err, e);
  endtask

  task automatic reject_case(input logic [1:0] d, input logic [5:0] l, input logic perr);
    bus.start = 1'b1;
    bus.dest  = d;
    bus.len   = l;
    @(negedge clk);
    bus.start = 1'b0;
    chk("reject_pulse", bus.reject, 1);
    chk("reject_ready", bus.ready, 1);
    chk("reject_pv", bus.packet_valid, 0);
    chk("reject_pl_ready", bus.pl_ready, 0);
    @(negedge clk);
    chk("reject_clear", bus.reject, 0);
    chk("reject_still_idle", bus.ready, 1);
    chk("reject_pkt_err", bus.pkt_err, perr);
  endtask

  task automatic timeout_case(input logic perr);
    int n;
    for (int j = 0; j < 5; j++) pay[j] = 8'($urandom);
    start_and_fill(2'd0, 6'd5, 0);
    bus.busy = 1'b1;
    n = 0;
    while (!bus.timeout && n < 50) begin
      chk("to_no_done", bus.done, 0);
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", n, TO);
    chk("timeout_pv", bus.packet_valid, 0);
    chk("timeout_dout", bus.dout, 0);
    chk("timeout_ready", bus.ready, 1);
    chk("timeout_no_done", bus.done, 0);
    chk("timeout_pkt_err", bus.pkt_err, perr);
    bus.busy = 1'b0;
    @(negedge clk);
    chk("timeout_clear", bus.timeout, 0);
  endtask

  task automatic reset_mid_case(input logic perr);
    for (int j = 0; j < 6; j++) pay[j] = 8'(8'hA0 + j);
    start_and_fill(2'd2, 6'd6, 0);
    bus.busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_payload_byte", bus.dout, 8'hA1);
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.ready, 1);
    chk("rst_dout", bus.dout, 0);
    chk("rst_pv", bus.packet_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_pkt_err", bus.pkt_err, 0);
    chk("rst_pl_ready", bus.pl_ready, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_done", bus.done, 0);
    chk("post_rst_timeout", bus.timeout, 0);
    chk("post_rst_ready", bus.ready, 1);
    if (perr) chk("rst_cleared_pkt_err", bus.pkt_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] rl;
    bus.start    = 1'b0;
    bus.dest     = '0;
    bus.len      = '0;
    bus.pl_data  = '0;
    bus.pl_valid = 1'b0;
    bus.busy     = 1'b0;
    bus.err      = 1'b0;
    resetn       = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", bus.ready, 1);
    chk("reset_pv", bus.packet_valid, 0);
    chk("reset_dout", bus.dout, 0);
    chk("reset_pl_ready", bus.pl_ready, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_pkt_err", bus.pkt_err, 0);
    chk("reset_reject", bus.reject, 0);
    chk("reset_timeout", bus.timeout, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Basic packet with no stalls, then the same packet with a two-cycle stall.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    run_packet(2'd1, 6'd4, 0, 0, 1'b0);
    run_packet(2'd1, 6'd4, 0, 1, 1'b0);

    reject_case(2'd3, 6'd5, 1'b0);
    reject_case(2'd1, 6'd0, 1'b0);

    // Maximum length with pl_valid toggling.
    for (int j = 0; j < 63; j++) pay[j] = 8'(j);
    run_packet(2'd0, 6'd63, 1, 0, 1'b0);

    // Router reports a parity error.
    for (int j = 0; j < 7; j++) pay[j] = 8'($urandom);
    run_packet(2'd2, 6'd7, 0, 0, 1'b1);
    reject_case(2'd3, 6'd0, 1'b1);

    timeout_case(1'b1);
    reset_mid_case(1'b1);

    for (int t = 0; t < 12; t++) begin
      rl = 6'($urandom_range(1, 63));
      for (int j = 0; j < 64; j++) pay[j] = 8'($urandom);
      run_packet(2'($urandom_range(0, 2)), rl, 2, 2, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter that drives the input side of the 1x3 router. It accepts a destination, a payload length and a payload byte stream from a host and buffers the whole payload. It then emits header, payload and parity bytes on `dout`/`packet_valid`, stalling whenever the router raises `busy`. After the packet it samples the router's `err` and reports pass/fail to the host.

## Interface
- `CHK_CYCLES`, default 3: cycles to wait after the parity byte is accepted before sampling `err`; legal range 1..15.
- `TIMEOUT`, default 255: consecutive `busy` cycles in any transmit state before the packet is aborted; legal range 1..65535.

- `clk`  in  1  clock; all logic on rising edge.
- `resetn`  in  1  synchronous reset, active low.
- `start`  in  1  request a packet; sampled only in IDLE.
- `dest`  in  2  destination port 0..2; captured on accepted `start`.
- `len`  in  6  payload length 1..63; captured on accepted `start`.
- `pl_data`  in  8  payload byte from host.
- `pl_valid`  in  1  `pl_data` valid.
- `pl_ready`  out  1  transmitter can take a payload byte; high only in FILL.
- `busy`  in  1  router busy; a byte on `dout` is accepted only at an edge where `busy`=0.
- `err`  in  1  router parity error flag.
- `packet_valid`  out  1  high during header and payload bytes; low during the parity byte.
- `dout`  out  8  byte to the router.
- `ready`  out  1  high in IDLE only.
- `done`  out  1  one-cycle pulse when the packet completes.
- `pkt_err`  out  1  `err` value sampled in CHECK; held until the next `done`.
- `reject`  out  1  one-cycle pulse when `start` is refused.
- `timeout`  out  1  one-cycle pulse when a packet is aborted.

## Operation
- Packet format:
  - Header = {len[5:0], dest[1:0]}.
  - Payload = `len` bytes in the order received.
  - Parity = XOR of the header and every payload byte.
- Internal resources: 64x8 payload buffer, 6-bit write and read indices, 8-bit parity accumulator, 16-bit busy counter, 4-bit check counter.
- States:
  - IDLE:
    - `start` with `dest`=3 or `len`=0: `reject` pulses and the block stays in IDLE.
    - Otherwise: capture `dest` and `len`, set parity to the header value, clear the indices, go to FILL.
  - FILL:
    - `pl_ready`=1.
    - On each edge with `pl_valid`=1: write `pl_data` to buf[wr_idx], XOR it into parity, increment wr_idx.
    - When the `len`-th byte is written: `pl_ready` drops, `dout` is loaded with the header, `packet_valid`=1, go to HEADER.
  - HEADER:
    - Edge with `busy`=0: `dout`=buf[0], rd_idx=1, go to PAYLOAD.
  - PAYLOAD:
    - Edge with `busy`=0 and rd_idx<`len`: `dout`=buf[rd_idx], increment rd_idx.
    - Edge with `busy`=0 and rd_idx=`len`: `dout`=parity, `packet_valid`=0, go to PARITY.
  - PARITY:
    - Edge with `busy`=0: `dout`=0, load the check counter with `CHK_CYCLES`, go to CHECK.
  - CHECK:
    - Decrement the check counter each cycle.
    - At the edge where it reaches 0: `pkt_err`<=`err`, `done` pulses, go to IDLE.
- Whenever `busy`=1 in HEADER, PAYLOAD or PARITY, `dout` and `packet_valid` hold their values.
- Timeout:
  - The busy counter increments on every `busy`=1 cycle in HEADER, PAYLOAD or PARITY, and clears on every `busy`=0 cycle and on state entry.
  - When the count reaches `TIMEOUT`: `packet_valid`=0, `dout`=0, `timeout` pulses, go to IDLE. `done` does not pulse and `pkt_err` is unchanged.
- `start` outside IDLE is ignored. A `start` in the same cycle as `done` or `timeout` is also ignored, because the block is not yet in IDLE.

## Timing
- Reset values, with `resetn`=0 at an edge:
  - state IDLE.
  - `packet_valid`, `dout`, `pl_ready`, `done`, `pkt_err`, `reject`, `timeout` all 0.
  - `ready`=1.
  - indices and counters cleared.
- Reset mid-packet aborts with no `done` or `timeout` pulse.
- All outputs are registered except `ready` and `pl_ready`, which decode directly from the state.
- Latencies:
  - Accepted `start` to FILL: 1 cycle.
  - Last payload byte written to header on `dout`: 1 cycle.
- With `busy` always 0:
  - The header is on `dout` for 1 cycle, each payload byte for 1 cycle, parity for 1 cycle.
  - `done` pulses `CHK_CYCLES` cycles after the parity byte is accepted.
- Each `busy`=1 cycle extends the current byte by exactly one cycle.

## Test plan
- dest=1, len=4, payload 0x11 0x22 0x33 0x44, `busy`=0, `err`=0 -> `dout` sequence 0x11, 0x11, 0x22, 0x33, 0x44 with `packet_valid`=1, then 0x55 with `packet_valid`=0; `done` pulses 3 cycles later; `pkt_err`=0.
- Same packet with `busy`=1 for the 2 cycles after the header is accepted -> 0x11 (payload byte 0) is held on `dout` for 3 cycles; the remaining sequence is unchanged.
- start with dest=3 -> `reject`=1 for 1 cycle, `ready` stays 1, `packet_valid` stays 0. start with len=0 -> same response.
- len=63 with payload 0..62 and `pl_valid` toggling every other cycle -> FILL takes 125 cycles; 63 payload bytes are sent in order; parity = 0xFC ^ XOR(0..62).
- TIMEOUT=8, `busy` stuck at 1 in HEADER -> `timeout` pulses after 8 busy cycles, `packet_valid`=0, `ready`=1 on the next cycle, no `done`.
- `err`=1 during CHECK -> `pkt_err`=1 with `done`. In a separate run, `resetn`=0 mid-PAYLOAD -> next cycle IDLE, `dout`=0, `packet_valid`=0, no pulses.
